// File: rtl/hbm_mvm_head_scheduler.sv
// ============================================================================
// Module   : hbm_mvm_head_scheduler
// Brief    : Issues one HBM MVM command per feature head (grouped-query weights).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hbm_mvm_head_scheduler #(
    parameter int AW = 32,
    parameter int HW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] cfg_dat_in_base,
    input  logic [AW-1:0] cfg_wt_base,
    input  logic [AW-1:0] cfg_dat_out_base,
    input  logic [AW-1:0] cfg_dat_in_head_stride,
    input  logic [AW-1:0] cfg_wt_head_stride,
    input  logic [AW-1:0] cfg_dat_out_head_stride,
    input  logic [HW-1:0] cfg_feature_head,
    input  logic [HW-1:0] cfg_heads_per_wt,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [AW-1:0] cmd_dat_in_addr,
    output logic [AW-1:0] cmd_wt_addr,
    output logic [AW-1:0] cmd_dat_out_addr,
    output logic [HW-1:0] cmd_head,
    output logic [HW-1:0] cmd_wt_head,
    input  logic          mvm_done,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_NEXT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_in_base, r_wt_base, r_out_base;
    logic [AW-1:0] r_in_stride, r_wt_stride, r_out_stride;
    logic [HW-1:0] r_num_heads, r_grp_size;
    logic [AW-1:0] r_in_addr, r_wt_addr, r_out_addr;
    logic [HW-1:0] r_head, r_grp, r_wt_head;
    logic          r_abort_pend;
    logic          r_err;

    logic          w_cfg_bad;
    logic          w_stop;

    assign w_cfg_bad = (r_num_heads == '0) || (r_grp_size == '0);
    // An abort raised in NEXT itself must also stop the run.
    assign w_stop    = (r_head == r_num_heads - HW'(1)) || r_abort_pend || abort;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = w_cfg_bad ? S_FINISH : S_ISSUE;
            S_ISSUE:  if (cmd_ready) w_state_nxt = S_WAIT;
            S_WAIT:   if (mvm_done) w_state_nxt = S_NEXT;
            S_NEXT:   w_state_nxt = w_stop ? S_FINISH : S_ISSUE;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_base    <= '0;
            r_wt_base    <= '0;
            r_out_base   <= '0;
            r_in_stride  <= '0;
            r_wt_stride  <= '0;
            r_out_stride <= '0;
            r_num_heads  <= '0;
            r_grp_size   <= '0;
            r_in_addr    <= '0;
            r_wt_addr    <= '0;
            r_out_addr   <= '0;
            r_head       <= '0;
            r_grp        <= '0;
            r_wt_head    <= '0;
            r_abort_pend <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == S_FINISH)
                r_abort_pend <= 1'b0;
            else if (r_state != S_IDLE && abort)
                r_abort_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in_base    <= cfg_dat_in_base;
                        r_wt_base    <= cfg_wt_base;
                        r_out_base   <= cfg_dat_out_base;
                        r_in_stride  <= cfg_dat_in_head_stride;
                        r_wt_stride  <= cfg_wt_head_stride;
                        r_out_stride <= cfg_dat_out_head_stride;
                        r_num_heads  <= cfg_feature_head;
                        r_grp_size   <= cfg_heads_per_wt;
                        r_err        <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_cfg_bad) begin
                        r_err <= 1'b1;
                    end else begin
                        r_head    <= '0;
                        r_grp     <= '0;
                        r_wt_head <= '0;
                        r_in_addr <= r_in_base;
                        r_wt_addr <= r_wt_base;
                        r_out_addr <= r_out_base;
                    end
                end
                S_NEXT: begin
                    if (!w_stop) begin
                        r_head     <= r_head + HW'(1);
                        r_in_addr  <= r_in_addr + r_in_stride;
                        r_out_addr <= r_out_addr + r_out_stride;
                        // Weight pointer moves only when a group of feature heads is exhausted.
                        if (r_grp == r_grp_size - HW'(1)) begin
                            r_grp     <= '0;
                            r_wt_head <= r_wt_head + HW'(1);
                            r_wt_addr <= r_wt_addr + r_wt_stride;
                        end else begin
                            r_grp <= r_grp + HW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_valid        = (r_state == S_ISSUE);
    assign cmd_dat_in_addr  = r_in_addr;
    assign cmd_wt_addr      = r_wt_addr;
    assign cmd_dat_out_addr = r_out_addr;
    assign cmd_head         = r_head;
    assign cmd_wt_head      = r_wt_head;
    assign busy             = (r_state == S_CHECK) || (r_state == S_ISSUE) ||
                              (r_state == S_WAIT)  || (r_state == S_NEXT);
    assign done             = (r_state == S_FINISH);
    assign err              = r_err;

endmodule

`default_nettype wire

// File: tb/tb_hbm_mvm_head_scheduler.sv
// ============================================================================
// Module   : tb_hbm_mvm_head_scheduler
// Brief    : Self-checking bench with an engine responder and a per-head model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hbm_mvm_head_scheduler;
    localparam int AW = 32;
    localparam int HW = 8;

    typedef struct packed {
        logic [AW-1:0] in_a;
        logic [AW-1:0] wt_a;
        logic [AW-1:0] out_a;
        logic [HW-1:0] head;
        logic [HW-1:0] wh;
    } cmd_t;
    typedef cmd_t cmd_q_t[$];

    logic          clk = 1'b0;
    logic          rst, start, abort, cmd_ready, mvm_done;
    logic [AW-1:0] cfg_dat_in_base, cfg_wt_base, cfg_dat_out_base;
    logic [AW-1:0] cfg_dat_in_head_stride, cfg_wt_head_stride, cfg_dat_out_head_stride;
    logic [HW-1:0] cfg_feature_head, cfg_heads_per_wt;
    logic          cmd_valid, busy, done, err;
    logic [AW-1:0] cmd_dat_in_addr, cmd_wt_addr, cmd_dat_out_addr;
    logic [HW-1:0] cmd_head, cmd_wt_head;

    hbm_mvm_head_scheduler #(.AW(AW), .HW(HW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_dat_in_base(cfg_dat_in_base), .cfg_wt_base(cfg_wt_base),
        .cfg_dat_out_base(cfg_dat_out_base),
        .cfg_dat_in_head_stride(cfg_dat_in_head_stride),
        .cfg_wt_head_stride(cfg_wt_head_stride),
        .cfg_dat_out_head_stride(cfg_dat_out_head_stride),
        .cfg_feature_head(cfg_feature_head), .cfg_heads_per_wt(cfg_heads_per_wt),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dat_in_addr(cmd_dat_in_addr), .cmd_wt_addr(cmd_wt_addr),
        .cmd_dat_out_addr(cmd_dat_out_addr), .cmd_head(cmd_head),
        .cmd_wt_head(cmd_wt_head), .mvm_done(mvm_done),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     ncyc     = 0;
    int     start_n, first_valid, last_done, last_mvm, done_cnt, valid_cnt;
    int     dly = 5;
    int     cnt = 0;
    int     stall_left = 0;
    bit     rand_mode = 0, force_stall = 0, spur = 0, prev_stall = 0, done_err = 0;
    cmd_t   snap;
    cmd_q_t rec_q;
    cmd_q_t exp_q;

    // Reference: head h reads base + h*stride; weight head is h/G.
    function automatic cmd_q_t model(input int f, input int g,
                                     input logic [AW-1:0] ib, wb, ob, is, ws, os);
        cmd_q_t q;
        cmd_t   c;
        for (int h = 0; h < f; h++) begin
            c.head  = HW'(h);
            c.wh    = HW'(h / g);
            c.in_a  = ib + AW'(h) * is;
            c.wt_a  = wb + AW'(h / g) * ws;
            c.out_a = ob + AW'(h) * os;
            q.push_back(c);
        end
        return q;
    endfunction

    // One clock: observe outputs at negedge, then drive the engine side for the next posedge.
    task automatic step();
        cmd_t c;
        @(negedge clk);
        ncyc++;
        c = '{in_a: cmd_dat_in_addr, wt_a: cmd_wt_addr, out_a: cmd_dat_out_addr,
              head: cmd_head, wh: cmd_wt_head};
        mvm_done = 1'b0;
        if (rst) begin
            cnt = 0; prev_stall = 0; cmd_ready = 1'b0;
        end else begin
            if (done) begin done_cnt++; last_done = ncyc; done_err = err; end
            if (cmd_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = ncyc;
            end
            if (prev_stall) begin
                n_checks++;
                if (!cmd_valid || c !== snap) begin
                    n_fail++;
                    $display("FAIL hold: valid=%0b cmd=%h required valid=1 cmd=%h", cmd_valid, c, snap);
                end
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin mvm_done = 1'b1; last_mvm = ncyc; end
            end else if (spur) begin
                mvm_done = 1'b1; spur = 0;
            end
            if (force_stall)                      cmd_ready = 1'b0;
            else if (cmd_valid && stall_left > 0) begin cmd_ready = 1'b0; stall_left--; end
            else                                  cmd_ready = 1'b1;
            if (cmd_valid && cmd_ready) begin
                rec_q.push_back(c);
                cnt = dly;
                stall_left = rand_mode ? int'($urandom_range(0, 7)) : 0;
            end
            prev_stall = cmd_valid && !cmd_ready;
            snap = c;
        end
    endtask

    task automatic launch(input int f, input int g, input logic [AW-1:0] ib, wb, ob, is, ws, os);
        cfg_feature_head = HW'(f);  cfg_heads_per_wt = HW'(g);
        cfg_dat_in_base = ib;  cfg_wt_base = wb;  cfg_dat_out_base = ob;
        cfg_dat_in_head_stride = is;  cfg_wt_head_stride = ws;  cfg_dat_out_head_stride = os;
        rec_q.delete();
        done_cnt = 0; valid_cnt = 0; first_valid = -1; last_done = -1; last_mvm = -1;
        start_n = ncyc;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            if (done_cnt > 0) ok = 1;
            else step();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen, required within 4000 cycles", name);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0; mvm_done = 1'b0;
        launch(0, 0, '0, '0, '0, '0, '0, '0);
        start = 1'b0;
        step(); step();
        n_checks++;
        if ({cmd_valid, busy, done, err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid/busy/done/err=%b required 0000", {cmd_valid, busy, done, err});
        end
        n_checks++;
        if ({cmd_dat_in_addr, cmd_wt_addr, cmd_dat_out_addr, cmd_head, cmd_wt_head} !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd: in=%h wt=%h out=%h head=%0d wh=%0d required all 0",
                     cmd_dat_in_addr, cmd_wt_addr, cmd_dat_out_addr, cmd_head, cmd_wt_head);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        rand_mode = 0; dly = 5;
        exp_q = model(32, 16, 32'h0, 32'h0200_0000, 32'h0800_0000, 32'h980, 32'h4000, 32'h980);
        launch(32, 16, 32'h0, 32'h0200_0000, 32'h0800_0000, 32'h980, 32'h4000, 32'h980);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: busy=%b required 1", busy); end
        wait_done("basic");
        n_checks++;
        if (rec_q.size() != 32) begin
            n_fail++; $display("FAIL basic_count: %0d commands required 32", rec_q.size());
        end
        for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (rec_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_cmd%0d: got %h required %h", i, rec_q[i], exp_q[i]);
            end
        end
        n_checks++;
        // 31 * 0x980 = 0x12680; weight head 1 begins at head 16.
        if (rec_q.size() < 32 || rec_q[31].in_a !== 32'h0001_2680 || rec_q[31].out_a !== 32'h0801_2680 ||
            rec_q[15].wh !== 8'd0 || rec_q[16].wh !== 8'd1 || rec_q[16].wt_a !== 32'h0200_4000) begin
            n_fail++; $display("FAIL basic_landmarks: size=%0d required 32 with head31 in=12680 out=8012680 head16 wt=2004000", rec_q.size());
        end
        n_checks++;
        if (first_valid - start_n != 2) begin
            n_fail++; $display("FAIL basic_first_valid: latency %0d required 2", first_valid - start_n);
        end
        n_checks++;
        if (done_cnt != 1 || last_done - last_mvm != 2) begin
            n_fail++; $display("FAIL basic_done: pulses=%0d latency=%0d required 1 and 2", done_cnt, last_done - last_mvm);
        end
    endtask

    task automatic test_back_pressure();
        int f, g;
        logic [AW-1:0] ib, wb, ob, is, ws, os;
        rand_mode = 1; dly = 5;
        exp_q = model(32, 16, 32'h0, 32'h0200_0000, 32'h0800_0000, 32'h980, 32'h4000, 32'h980);
        launch(32, 16, 32'h0, 32'h0200_0000, 32'h0800_0000, 32'h980, 32'h4000, 32'h980);
        wait_done("bp");
        n_checks++;
        if (rec_q !== exp_q) begin
            n_fail++; $display("FAIL bp_sequence: %0d commands, required %0d identical to no-stall run", rec_q.size(), exp_q.size());
        end
        for (int t = 0; t < 4; t++) begin
            f = $urandom_range(1, 12); g = $urandom_range(1, 5); dly = $urandom_range(1, 4);
            ib = $urandom; wb = $urandom; ob = $urandom;
            is = $urandom; ws = $urandom; os = $urandom;
            exp_q = model(f, g, ib, wb, ob, is, ws, os);
            launch(f, g, ib, wb, ob, is, ws, os);
            wait_done("rand");
            n_checks++;
            if (rec_q.size() != f) begin
                n_fail++; $display("FAIL rand%0d_count: %0d commands required %0d", t, rec_q.size(), f);
            end
            for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (rec_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d_cmd%0d: got %h required %h", t, i, rec_q[i], exp_q[i]);
                end
            end
        end
        rand_mode = 0;
    endtask

    task automatic test_cfg_error();
        for (int t = 0; t < 2; t++) begin
            launch(t == 0 ? 0 : 3, t == 0 ? 3 : 0, 32'h100, 32'h200, 32'h300, 32'h10, 32'h20, 32'h30);
            wait_done("cfgerr");
            n_checks++;
            if (valid_cnt != 0 || done_err !== 1'b1 || last_done - start_n != 2) begin
                n_fail++;
                $display("FAIL cfgerr%0d: valid_cycles=%0d err=%b done_latency=%0d required 0, 1, 2",
                         t, valid_cnt, done_err, last_done - start_n);
            end
        end
        dly = 2;
        launch(2, 1, 32'h100, 32'h200, 32'h300, 32'h10, 32'h20, 32'h30);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL cfgerr_clear: err=%b required 0", err); end
        wait_done("cfgerr_clear");
        n_checks++;
        if (rec_q.size() != 2 || done_err !== 1'b0) begin
            n_fail++; $display("FAIL cfgerr_rerun: %0d commands err=%b required 2 and 0", rec_q.size(), done_err);
        end
    endtask

    task automatic test_abort();
        dly = 5;
        exp_q = model(8, 2, 32'h1000, 32'h5000, 32'h9000, 32'h40, 32'h400, 32'h80);
        launch(8, 2, 32'h1000, 32'h5000, 32'h9000, 32'h40, 32'h400, 32'h80);
        for (int i = 0; i < 500 && rec_q.size() < 4; i++) step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done("abort");
        n_checks++;
        if (rec_q.size() != 4 || last_done - last_mvm != 2) begin
            n_fail++; $display("FAIL abort_stop: %0d commands done_latency=%0d required 4 and 2", rec_q.size(), last_done - last_mvm);
        end
        for (int i = 0; i < rec_q.size() && i < 4; i++) begin
            n_checks++;
            if (rec_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL abort_cmd%0d: got %h required %h", i, rec_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_rst_midrun();
        bit hit = 0;
        dly = 3;
        launch(8, 4, 32'hAA00, 32'hBB00, 32'hCC00, 32'h100, 32'h200, 32'h300);
        for (int i = 0; i < 500 && rec_q.size() < 2; i++) step();
        force_stall = 1;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (cmd_valid && cmd_head == 8'd2) hit = 1;
            else step();
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (!hit || {cmd_valid, busy, done, err, cmd_dat_in_addr, cmd_wt_addr, cmd_dat_out_addr,
                     cmd_head, cmd_wt_head} !== '0) begin
            n_fail++; $display("FAIL rst_midrun: reached=%b valid=%b busy=%b head=%0d in=%h required all 0",
                               hit, cmd_valid, busy, cmd_head, cmd_dat_in_addr);
        end
        rst = 1'b0; force_stall = 0;
        step();
        exp_q = model(3, 1, 32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h8, 32'h10, 32'h18);
        launch(3, 1, 32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h8, 32'h10, 32'h18);
        wait_done("rst_restart");
        n_checks++;
        if (rec_q !== exp_q) begin
            n_fail++; $display("FAIL rst_restart: %0d commands first=%h required %0d first=%h",
                               rec_q.size(), rec_q.size() > 0 ? rec_q[0] : '0, exp_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_spurious();
        bit hit = 0;
        spur = 1;
        step(); step(); step();
        n_checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL spur_idle: busy=%b valid=%b required 0 0", busy, cmd_valid);
        end
        dly = 4;
        exp_q = model(4, 2, 32'h3000, 32'h4000, 32'h5000, 32'h20, 32'h100, 32'h40);
        launch(4, 2, 32'h3000, 32'h4000, 32'h5000, 32'h20, 32'h100, 32'h40);
        cfg_feature_head = 8'd1; cfg_heads_per_wt = 8'd7;
        cfg_dat_in_base = 32'hDEAD_0000; cfg_dat_in_head_stride = 32'h1;
        force_stall = 1;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (cmd_valid) hit = 1;
            else step();
        end
        spur = 1;
        step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        force_stall = 0;
        wait_done("spur");
        n_checks++;
        if (!hit || rec_q !== exp_q || done_cnt != 1) begin
            n_fail++; $display("FAIL spur_sequence: reached=%b %0d commands done_pulses=%0d required 4 matching and 1",
                               hit, rec_q.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_cfg_error();
        test_abort();
        test_rst_midrun();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
